// File: rtl/encodeur_bcd.sv
// encodeur_bcd: sequential reverse double-dabble converter.
// It turns a 3-digit BCD value (cent/dix/unite) into 8-bit binary.
// It performs one shift per clock, so a conversion takes 8 shift cycles plus 1 done cycle.
//
// Ports
//   clk    in   1  system clock, rising edge
//   rst    in   1  synchronous, active-high reset
//   start  in   1  request a conversion (taken in IDLE, or back-to-back on the done edge)
//   cent   in   2  hundreds digit (0..2 valid)
//   dix    in   4  tens digit (0..9 valid)
//   unite  in   4  units digit (0..9 valid)
//   bin    out  8  binary result, held until the next done
//   busy   out  1  conversion in progress (SHIFT or DONE)
//   done   out  1  one-cycle pulse, bin/err valid
//   err    out  1  last conversion had a non-BCD or >255 input, held with bin
module encodeur_bcd #(
  parameter logic [7:0] ERR_VAL = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] cent,
  input  logic [3:0] dix,
  input  logic [3:0] unite,
  output logic [7:0] bin,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int unsigned SR_W  = 18;
  localparam int unsigned CNT_W = 3;
  localparam int unsigned BIN_W = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [SR_W-1:0]    r_sr;
  logic [SR_W-1:0]    w_sr_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               r_err_i;
  logic               w_err_i_nxt;
  logic [BIN_W-1:0]   r_bin;
  logic [BIN_W-1:0]   w_bin_nxt;
  logic               r_err;
  logic               w_err_nxt;
  logic               r_done;
  logic               w_done_nxt;
  logic               r_busy;
  logic               w_busy_nxt;

  logic               w_invalid;
  logic [SR_W-1:0]    w_sr_shr;
  logic [SR_W-1:0]    w_sr_adj;

  // Non-BCD digit or a value above 255 (2xx with a tail above 55).
  assign w_invalid = (dix > 4'd9) | (unite > 4'd9) | (cent == 2'd3) |
                     ((cent == 2'd2) && ({dix, unite} > 8'h55));

  // One reverse double-dabble step: shift right, then fix the tens and units nibbles that reached 8 or more.
  // Hundreds only ever hold 0..2, so they never need a correction.
  always_comb begin
    w_sr_shr = r_sr >> 1;
    w_sr_adj = w_sr_shr;
    if (w_sr_shr[15:12] >= 4'd8) w_sr_adj[15:12] = 4'(w_sr_shr[15:12] - 4'd3);
    if (w_sr_shr[11:8]  >= 4'd8) w_sr_adj[11:8]  = 4'(w_sr_shr[11:8]  - 4'd3);
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt = r_state;
    w_sr_nxt    = r_sr;
    w_cnt_nxt   = r_cnt;
    w_err_i_nxt = r_err_i;
    w_bin_nxt   = r_bin;
    w_err_nxt   = r_err;
    w_done_nxt  = 1'b0;
    w_busy_nxt  = r_busy;

    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_sr_nxt    = {cent, dix, unite, 8'h00};
          w_err_i_nxt = w_invalid;
          w_cnt_nxt   = '0;
          w_busy_nxt  = 1'b1;
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        w_sr_nxt  = w_sr_adj;
        w_cnt_nxt = CNT_W'(r_cnt + 3'd1);
        if (r_cnt == 3'd7) begin
          w_bin_nxt   = r_err_i ? ERR_VAL : w_sr_adj[7:0];
          w_err_nxt   = r_err_i;
          w_done_nxt  = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        // A start present on the done edge chains directly into the next conversion.
        // Held-high start therefore gives a 9-cycle period.
        if (start) begin
          w_sr_nxt    = {cent, dix, unite, 8'h00};
          w_err_i_nxt = w_invalid;
          w_cnt_nxt   = '0;
          w_busy_nxt  = 1'b1;
          w_state_nxt = S_SHIFT;
        end else begin
          w_busy_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_sr    <= '0;
      r_cnt   <= '0;
      r_err_i <= 1'b0;
      r_bin   <= '0;
      r_err   <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sr    <= w_sr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_err_i <= w_err_i_nxt;
      r_bin   <= w_bin_nxt;
      r_err   <= w_err_nxt;
      r_done  <= w_done_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  assign bin  = r_bin;
  assign err  = r_err;
  assign done = r_done;
  assign busy = r_busy;

endmodule

// File: tb/tb_encodeur_bcd.sv
// Testbench for encodeur_bcd.
// It covers directed vectors, the back-to-back/ignore/reset corner sequences, and full input sweeps.
module tb_encodeur_bcd;

  localparam logic [7:0] TB_ERR_VAL = 8'hEE;

  logic       clk;
  logic       rst;
  logic       start;
  logic [1:0] cent;
  logic [3:0] dix;
  logic [3:0] unite;
  logic [7:0] bin;
  logic       busy;
  logic       done;
  logic       err;

  int checks = 0;
  int errors = 0;

  encodeur_bcd #(.ERR_VAL(TB_ERR_VAL)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .cent  (cent),
    .dix   (dix),
    .unite (unite),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0] c;
    logic [3:0] d;
    logic [3:0] u;
    logic [7:0] eb;
    logic       ee;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Start one conversion and check the busy latency, the done position, the result and the release.
  // The task is entered at any time; it aligns to a falling edge before driving.
  task automatic run_conv(input logic [1:0] c, input logic [3:0] d, input logic [3:0] u,
                          input logic [7:0] eb, input logic ee, input string nm);
    int k;
    @(negedge clk);
    cent = c; dix = d; unite = u; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk({nm, "_busy_on"}, 32'(busy), 32'd1);
    k = 1;
    while (!done && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk({nm, "_latency"}, 32'(k), 32'd9);
    chk({nm, "_bin"}, 32'(bin), 32'(eb));
    chk({nm, "_err"}, 32'(err), 32'(ee));
    @(negedge clk);
    chk({nm, "_done_pulse"}, 32'(done), 32'd0);
    chk({nm, "_busy_off"}, 32'(busy), 32'd0);
    chk({nm, "_bin_held"}, 32'(bin), 32'(eb));
  endtask

  vec_t vecs[13];

  initial begin
    int dn;
    int v;
    logic [7:0] mb;
    logic       me;

    vecs[0]  = '{2'd2, 4'd5, 4'd5, 8'hFF, 1'b0};
    vecs[1]  = '{2'd0, 4'd0, 4'd0, 8'h00, 1'b0};
    vecs[2]  = '{2'd1, 4'd2, 4'd8, 8'h80, 1'b0};
    vecs[3]  = '{2'd0, 4'd0, 4'd9, 8'h09, 1'b0};
    vecs[4]  = '{2'd2, 4'd5, 4'd6, TB_ERR_VAL, 1'b1};
    vecs[5]  = '{2'd0, 4'hA, 4'd0, TB_ERR_VAL, 1'b1};
    vecs[6]  = '{2'd1, 4'd0, 4'd0, 8'h64, 1'b0};
    vecs[7]  = '{2'd0, 4'd9, 4'd9, 8'h63, 1'b0};
    vecs[8]  = '{2'd3, 4'd0, 4'd0, TB_ERR_VAL, 1'b1};
    vecs[9]  = '{2'd0, 4'd0, 4'hF, TB_ERR_VAL, 1'b1};
    vecs[10] = '{2'd2, 4'd4, 4'd9, 8'hF9, 1'b0};
    vecs[11] = '{2'd1, 4'd5, 4'd0, 8'h96, 1'b0};
    vecs[12] = '{2'd0, 4'd4, 4'd2, 8'h2A, 1'b0};

    rst = 1'b1; start = 1'b0; cent = '0; dix = '0; unite = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_bin", 32'(bin), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst = 1'b0;

    foreach (vecs[i])
      run_conv(vecs[i].c, vecs[i].d, vecs[i].u, vecs[i].eb, vecs[i].ee, $sformatf("vec%0d", i));

    // start held high: conversions at E0, E9 and E18; inputs are changed before E9.
    @(negedge clk);
    cent = 2'd1; dix = 4'd2; unite = 4'd8; start = 1'b1;
    @(posedge clk);
    dn = 0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      chk($sformatf("b2b_done_n%0d", n), 32'(done), 32'((n == 9) || (n == 18) || (n == 27)));
      if (done) dn++;
      if (n == 9)  chk("b2b_bin1", 32'(bin), 32'h80);
      if (n == 18) chk("b2b_bin2", 32'(bin), 32'h2A);
      if (n == 27) chk("b2b_bin3", 32'(bin), 32'h2A);
      if (n == 10) chk("b2b_busy_kept", 32'(busy), 32'd1);
      if (n == 28) chk("b2b_busy_off", 32'(busy), 32'd0);
      if (n == 9)  begin cent = 2'd0; dix = 4'd4; unite = 4'd2; end
      if (n == 19) start = 1'b0;
    end
    chk("b2b_done_count", 32'(dn), 32'd3);

    // A start pulse and new inputs in mid-conversion must be ignored.
    @(negedge clk);
    cent = 2'd1; dix = 4'd2; unite = 4'd8; start = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      chk($sformatf("ign_done_n%0d", n), 32'(done), 32'(n == 9));
      if (n == 9) begin
        chk("ign_bin", 32'(bin), 32'h80);
        chk("ign_err", 32'(err), 32'd0);
      end
      if (n == 1) start = 1'b0;
      if (n == 3) begin cent = 2'd0; dix = 4'd0; unite = 4'd9; start = 1'b1; end
      if (n == 4) start = 1'b0;
    end

    // A reset at E4 aborts the conversion, so no done follows.
    @(negedge clk);
    cent = 2'd2; dix = 4'd4; unite = 4'd9; start = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
      if (n == 4) rst = 1'b1;
    end
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_bin", 32'(bin), 32'd0);
    chk("abort_err", 32'(err), 32'd0);
    rst = 1'b0;
    dn = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("abort_no_done", 32'(dn), 32'd0);
    run_conv(2'd0, 4'd4, 4'd2, 8'h2A, 1'b0, "after_abort");

    // Reset wins over start.
    @(negedge clk);
    rst = 1'b1; start = 1'b1; cent = 2'd1; dix = 4'd0; unite = 4'd0;
    @(negedge clk);
    chk("rst_start_busy", 32'(busy), 32'd0);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("rst_start_idle", 32'(busy), 32'd0);

    // The full input space is checked against an arithmetic reference model.
    for (int c = 0; c < 4; c++)
      for (int d = 0; d < 16; d++)
        for (int u = 0; u < 16; u++) begin
          v  = c * 100 + d * 10 + u;
          me = (d > 9) || (u > 9) || (v > 255);
          mb = me ? TB_ERR_VAL : 8'(v);
          run_conv(2'(c), 4'(d), 4'(u), mb, me, $sformatf("sw_%0d_%0d_%0d", c, d, u));
        end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
